// File: rtl/addsub_regfile_pipe.sv
// addsub_regfile_pipe
//   Two-stage signed add/subtract unit with an integrated DEPTH-entry operand
//   register file, optional signed saturation and result writeback.
//   S1 holds the latched operands/opcode; S2 holds the registered result.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data    host write into the register file
//   in_valid/in_ready        operation request handshake
//   op_sub, op_sat, op_wb    subtract / saturate / write result to dst
//   src_a, src_b, dst        register addresses
//   out_valid/out_ready      result handshake
//   out_result               final (optionally saturated) result
//   out_overflow, out_carry  raw signed overflow / carry out of MSB
//   out_zero, out_neg        derived from out_result
module addsub_regfile_pipe #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic             op_sat,
  input  logic             op_wb,
  input  logic [AW-1:0]    src_a,
  input  logic [AW-1:0]    src_b,
  input  logic [AW-1:0]    dst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_overflow,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_neg
);

  logic [WIDTH-1:0] rf [DEPTH];

  // S1 operand register
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_sub;
  logic             s1_sat;
  logic             s1_wb;
  logic [AW-1:0]    s1_dst;

  // S1 combinational arithmetic
  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   raw;
  logic [WIDTH-1:0] low;
  logic             carry_msb_in;
  logic             ovf;
  logic [WIDTH-1:0] result;

  logic             advance;
  logic             accept;
  logic             wb_fire;
  logic             fwd_a;
  logic             fwd_b;
  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] opnd_b;

  always_comb begin
    b_x = s1_b ^ {WIDTH{s1_sub}};
    raw = {1'b0, s1_a} + {1'b0, b_x} + (WIDTH+1)'(s1_sub);
    // Sum of the low WIDTH-1 bits; its top bit is the carry into the MSB.
    low = {1'b0, s1_a[WIDTH-2:0]} + {1'b0, b_x[WIDTH-2:0]} + WIDTH'(s1_sub);
    carry_msb_in = low[WIDTH-1];
    ovf = carry_msb_in ^ raw[WIDTH];
    result = raw[WIDTH-1:0];
    if (s1_sat && ovf) begin
      result = s1_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                             : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    advance  = !out_valid || out_ready;
    in_ready = !s1_valid || advance;
    accept   = in_valid && in_ready;
    wb_fire  = s1_valid && s1_wb && advance;
    // The writeback of the op leaving S1 lands on the same edge the new
    // operands are latched, so the register file would still be stale.
    fwd_a    = wb_fire && (src_a == s1_dst);
    fwd_b    = wb_fire && (src_b == s1_dst);
    opnd_a   = fwd_a ? result : rf[src_a];
    opnd_b   = fwd_b ? result : rf[src_b];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rf[i] <= '0;
      end
      s1_valid     <= 1'b0;
      s1_a         <= '0;
      s1_b         <= '0;
      s1_sub       <= 1'b0;
      s1_sat       <= 1'b0;
      s1_wb        <= 1'b0;
      s1_dst       <= '0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_overflow <= 1'b0;
      out_carry    <= 1'b0;
      out_zero     <= 1'b0;
      out_neg      <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_a     <= opnd_a;
        s1_b     <= opnd_b;
        s1_sub   <= op_sub;
        s1_sat   <= op_sat;
        s1_wb    <= op_wb;
        s1_dst   <= dst;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end

      if (advance) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_result   <= result;
          out_overflow <= ovf;
          out_carry    <= raw[WIDTH];
          out_zero     <= (result == '0);
          out_neg      <= result[WIDTH-1];
        end
      end

      // Writeback is assigned after the host write so it wins on an
      // address collision.
      if (wr_en) begin
        rf[wr_addr] <= wr_data;
      end
      if (wb_fire) begin
        rf[s1_dst] <= result;
      end
    end
  end

endmodule

// File: tb/tb_addsub_regfile_pipe.sv
module tb_addsub_regfile_pipe;

  localparam int W = 8;
  localparam int D = 4;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         sat;
    logic         wb;
    logic [1:0]   dst;
  } op_t;

  typedef struct packed {
    logic [W-1:0] res;
    logic         ovf;
    logic         carry;
    logic         zero;
    logic         neg;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic [1:0]   wr_addr = '0;
  logic [W-1:0] wr_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         op_sub = 1'b0;
  logic         op_sat = 1'b0;
  logic         op_wb = 1'b0;
  logic [1:0]   src_a = '0;
  logic [1:0]   src_b = '0;
  logic [1:0]   dst = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         out_overflow;
  logic         out_carry;
  logic         out_zero;
  logic         out_neg;

  int total = 0;
  int bad = 0;

  // Reference state
  logic [W-1:0] mreg [D];
  logic         m_s1_v;
  op_t          m_s1;
  logic         m_s2_full;
  exp_t         sb_q [$];

  always #5 clk = ~clk;

  addsub_regfile_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .op_sat(op_sat), .op_wb(op_wb),
    .src_a(src_a), .src_b(src_b), .dst(dst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow),
    .out_carry(out_carry), .out_zero(out_zero), .out_neg(out_neg)
  );

  // Plain signed/unsigned integer arithmetic.
  function automatic exp_t calc(input op_t o);
    exp_t e;
    int sa, sb, s;
    logic [W-1:0] r;
    sa = int'($signed(o.a));
    sb = int'($signed(o.b));
    s  = o.sub ? sa - sb : sa + sb;
    r  = W'(s);
    e.ovf   = (s > 127) || (s < -128);
    e.carry = o.sub ? (int'(o.a) >= int'(o.b)) : ((int'(o.a) + int'(o.b)) > 255);
    e.res   = (o.sat && e.ovf) ? ((sa >= 0) ? 8'h7F : 8'h80) : r;
    e.zero  = (e.res == 8'h00);
    e.neg   = e.res[W-1];
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < D; i++) mreg[i] = '0;
    m_s1_v = 1'b0;
    m_s1 = '0;
    m_s2_full = 1'b0;
    sb_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== '0 ||
        out_overflow !== 1'b0 || out_carry !== 1'b0 || out_zero !== 1'b0 || out_neg !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got valid=%b ready=%b res=%h ovf=%b c=%b z=%b n=%b, want valid=0 ready=1 all zero",
               out_valid, in_ready, out_result, out_overflow, out_carry, out_zero, out_neg);
    end
  endtask

  // One clock of stimulus; checks in_ready and advances the reference.
  task automatic cycle(input logic wv, input logic [1:0] wa, input logic [W-1:0] wd,
                       input logic iv, input logic sub, input logic sat, input logic wb,
                       input logic [1:0] sa, input logic [1:0] sbb, input logic [1:0] d,
                       input logic ordy, output logic acc);
    logic adv, rdy, wb_hit;
    logic [1:0] wb_dst;
    exp_t e;
    op_t n;
    @(negedge clk);
    wr_en = wv; wr_addr = wa; wr_data = wd;
    in_valid = iv; op_sub = sub; op_sat = sat; op_wb = wb;
    src_a = sa; src_b = sbb; dst = d; out_ready = ordy;
    #1;
    adv = !m_s2_full || ordy;
    rdy = !m_s1_v || adv;
    total++;
    if (in_ready !== rdy) begin
      bad++;
      $display("FAIL in_ready: got %b want %b", in_ready, rdy);
    end
    acc = iv && rdy;
    @(posedge clk);
    wb_hit = 1'b0;
    wb_dst = m_s1.dst;
    if (adv && m_s1_v) begin
      e = calc(m_s1);
      sb_q.push_back(e);
      if (m_s1.wb) begin
        mreg[m_s1.dst] = e.res;
        wb_hit = 1'b1;
      end
      m_s2_full = 1'b1;
    end else if (adv) begin
      m_s2_full = 1'b0;
    end
    n.a = mreg[sa]; n.b = mreg[sbb];
    n.sub = sub; n.sat = sat; n.wb = wb; n.dst = d;
    if (wv && !(wb_hit && wa == wb_dst)) mreg[wa] = wd;
    if (acc) begin
      m_s1 = n;
      m_s1_v = 1'b1;
    end else if (adv) begin
      m_s1_v = 1'b0;
    end
  endtask

  task automatic hw(input logic [1:0] a, input logic [W-1:0] v);
    logic acc;
    cycle(1'b1, a, v, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, acc);
  endtask

  task automatic op(input logic sub, input logic sat, input logic wb,
                    input logic [1:0] sa, input logic [1:0] sbb, input logic [1:0] d);
    logic acc;
    cycle(1'b0, 2'd0, '0, 1'b1, sub, sat, wb, sa, sbb, d, 1'b1, acc);
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL op_accept: got accepted=0 want 1");
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++)
      cycle(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, acc);
  endtask

  // Monitor / scoreboard
  initial begin
    logic stalled;
    exp_t held, got, e;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #3;
      got = {out_result, out_overflow, out_carry, out_zero, out_neg};
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          total++;
          if (out_valid !== 1'b1 || got !== held) begin
            bad++;
            $display("FAIL hold_stable: got valid=%b res=%h flags=%b want valid=1 res=%h flags=%b",
                     out_valid, got.res, got[3:0], held.res, held[3:0]);
          end
        end
        if (out_valid && out_ready) begin
          total++;
          if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL result_unexpected: got res=%h with empty expectation queue", got.res);
          end else begin
            e = sb_q.pop_front();
            if (got !== e) begin
              bad++;
              $display("FAIL result: got res=%h ovf=%b c=%b z=%b n=%b want res=%h ovf=%b c=%b z=%b n=%b",
                       got.res, got.ovf, got.carry, got.zero, got.neg,
                       e.res, e.ovf, e.carry, e.zero, e.neg);
            end
          end
        end
        stalled = out_valid && !out_ready;
        held = got;
      end
    end
  end

  // Stimulus
  initial begin
    logic acc;
    int idx;
    op_t bp [3];
    op_t pend;
    logic pend_v;
    model_clear();
    do_reset();

    // Add overflow, then saturated
    hw(2'd0, 8'h7F);
    hw(2'd1, 8'h01);
    op(1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0);
    op(1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 2'd0);
    idle(2);

    // Subtract overflow, saturated, and zero result
    hw(2'd2, 8'h80);
    hw(2'd3, 8'h05);
    op(1'b1, 1'b0, 1'b0, 2'd2, 2'd1, 2'd0);
    op(1'b1, 1'b1, 1'b0, 2'd2, 2'd1, 2'd0);
    op(1'b1, 1'b0, 1'b0, 2'd3, 2'd3, 2'd0);
    idle(2);

    // Back-to-back forwarding chain
    hw(2'd1, 8'h03);
    hw(2'd2, 8'h04);
    op(1'b0, 1'b0, 1'b1, 2'd1, 2'd2, 2'd3);
    op(1'b0, 1'b0, 1'b1, 2'd3, 2'd3, 2'd0);
    idle(2);
    op(1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 2'd1);
    idle(2);

    // Backpressure: three offered, out_ready low
    bp[0] = '{a: '0, b: '0, sub: 1'b0, sat: 1'b0, wb: 1'b0, dst: 2'd1};
    bp[1] = '{a: '0, b: '0, sub: 1'b1, sat: 1'b0, wb: 1'b0, dst: 2'd2};
    bp[2] = '{a: '0, b: '0, sub: 1'b0, sat: 1'b1, wb: 1'b0, dst: 2'd3};
    idx = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 2'd0, '0, 1'b1, bp[idx].sub, bp[idx].sat, 1'b0,
            2'(idx), 2'(idx + 1), bp[idx].dst, 1'b0, acc);
      if (acc) idx++;
    end
    total++;
    if (idx != 2) begin
      bad++;
      $display("FAIL bp_accepts: got %0d want 2", idx);
    end
    for (int i = 0; i < 10 && idx < 3; i++) begin
      cycle(1'b0, 2'd0, '0, 1'b1, bp[idx].sub, bp[idx].sat, 1'b0,
            2'(idx), 2'(idx + 1), bp[idx].dst, 1'b1, acc);
      if (acc) idx++;
    end
    idle(3);

    // Host write colliding with writeback, then non-colliding
    hw(2'd1, 8'h11);
    hw(2'd2, 8'h00);
    op(1'b1, 1'b0, 1'b1, 2'd1, 2'd2, 2'd3);
    cycle(1'b1, 2'd3, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, acc);
    op(1'b1, 1'b0, 1'b0, 2'd3, 2'd2, 2'd0);
    hw(2'd3, 8'h22);
    op(1'b1, 1'b0, 1'b1, 2'd1, 2'd2, 2'd3);
    cycle(1'b1, 2'd0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, acc);
    op(1'b1, 1'b0, 1'b0, 2'd3, 2'd2, 2'd0);
    op(1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0);
    idle(3);

    // Randomised traffic
    pend_v = 1'b0;
    pend = '0;
    for (int i = 0; i < 400; i++) begin
      logic [1:0] sa, sbb;
      if (!pend_v && ($urandom_range(0, 9) < 6)) begin
        pend.sub = 1'($urandom);
        pend.sat = 1'($urandom);
        pend.wb  = 1'($urandom);
        pend.dst = 2'($urandom);
        pend.a   = 8'($urandom_range(0, 3));
        pend.b   = 8'($urandom_range(0, 3));
        pend_v = 1'b1;
      end
      sa = pend.a[1:0];
      sbb = pend.b[1:0];
      cycle(($urandom_range(0, 9) < 3), 2'($urandom), 8'($urandom),
            pend_v, pend.sub, pend.sat, pend.wb, sa, sbb, pend.dst,
            ($urandom_range(0, 9) < 7), acc);
      if (acc) pend_v = 1'b0;
    end
    idle(3);

    // Reset with both stages full
    hw(2'd0, 8'h80);
    hw(2'd1, 8'h41);
    cycle(1'b0, 2'd0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1, 2'd2, 1'b0, acc);
    cycle(1'b0, 2'd0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 2'd3, 1'b0, acc);
    do_reset();
    for (int i = 0; i < D; i++) op(1'b0, 1'b0, 1'b0, 2'(i), 2'(i), 2'd0);

    // Drain with a bounded wait
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) idle(1);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending results want 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addsub_regfile_pipe.md
# addsub_regfile_pipe

Parametrised two-stage add/subtract unit with an integrated DEPTH-entry operand register file, signed saturation and valid/ready handshakes on both sides. It generalises the 8-bit, four-source add/subtract datapath to any width and source count. Results are written back into the register file, so dependent operations can be chained without host involvement. It sits between the host/sequencer issuing opcodes and the downstream result consumer.

## Interface
- WIDTH, 8: operand/result width in bits (≥2)
- DEPTH, 4: register-file entries (power of two, ≥2)
- AW, $clog2(DEPTH): register address width (derived, not overridden)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  host write to register file
- wr_addr  in  AW  host write address
- wr_data  in  WIDTH  host write data
- in_valid  in  1  operation request valid
- in_ready  out  1  unit can accept a request this cycle
- op_sub  in  1  0: A+B, 1: A−B (two's complement, B inverted, carry-in 1)
- op_sat  in  1  clamp to signed min/max on overflow
- op_wb  in  1  write result to register dst
- src_a, src_b, dst  in  AW each  register addresses
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  WIDTH  result (saturated if op_sat)
- out_overflow  out  1  signed overflow of the raw (unsaturated) sum
- out_carry  out  1  carry out of MSB (for subtract: 1 = no borrow)
- out_zero, out_neg  out  1 each  out_result == 0 / out_result[WIDTH-1]

## Operation
- Stage S1 (operand register): on accept (in_valid && in_ready), latch A, B, op_sub, op_sat, op_wb, dst.
- Stage S2 (result register): on S1→S2 advance, compute raw = A + (B ^ {WIDTH{op_sub}}) + op_sub in WIDTH+1 bits; carry = raw[WIDTH]; overflow = carry into MSB XOR carry out of MSB.
- Saturation: if op_sat && overflow, result = 0 1…1 (max positive) when A[MSB]==0, else 1 0…0 (min negative); else result = raw[WIDTH-1:0]. Flags zero/neg come from the final result; overflow/carry are always raw.
- Writeback: if op_wb, result written to reg[dst] on the same edge S2 loads. A stalled S2 never rewrites.
- Forwarding: an incoming src_a/src_b equal to S1's dst, with S1 valid, op_wb set and S1 advancing this cycle, takes S1's computed result instead of the register file.
- Host write vs writeback, same address, same edge: writeback wins and the host write is dropped. Different addresses: both occur.
- Host write vs operand read, same cycle: the read sees the old value (no host-write bypass).
- src_a == src_b is legal. dst may equal either source.

## Timing
- advance = !s2_valid || out_ready. in_ready = !s1_valid || advance (combinational path from out_ready).
- Latency: accept at edge t → out_valid high after edge t+1. Throughput is one operation per cycle with out_ready held high.
- S2 outputs are held stable while out_valid && !out_ready.
- s1_valid clears on advance with no new accept. out_valid clears on out_ready with nothing advancing.
- Reset (any cycle, including mid-operation): all registers = 0, s1_valid = 0, out_valid = 0, all out_* = 0, in_ready = 1 on the first cycle after reset. In-flight operations are discarded with no writeback.

## Test plan
- Reset, host-load reg0=0x7F, reg1=0x01; op A=0,B=1 add, no sat -> out_result=0x80, overflow=1, carry=0, neg=1; with op_sat -> 0x7F.
- reg2=0x80, reg1=0x01; subtract A=2,B=1 -> raw 0x7F, overflow=1, carry=1; with op_sat -> 0x80. Subtract 0x05−0x05 -> 0x00, zero=1, carry=1.
- Back-to-back forwarding: reg1=3, reg2=4; op0 reg3=reg1+reg2 (wb); next cycle op1 reg0=reg3+reg3 (wb) -> op1 result 0x0E, reg3=0x07, reg0=0x0E.
- Backpressure: out_ready=0 for 3 cycles with 3 ops offered -> in_ready low after 2 accepts, out_result stable; release -> results in order, no loss or duplicate.
- Collision: host wr_addr=3 data 0xAA on the same edge as writeback to reg3=0x11 -> reg3=0x11. Different addresses -> both written.
- rst asserted while S1 and S2 are full -> next cycle out_valid=0, in_ready=1, all regs 0, no writeback occurred.
